// File: rtl/psys_route_pkg.sv
// Shared constants and types for the systolic-array data-route width converters.
package psys_route_pkg;

  localparam int unsigned PSYS_NARROW_W = 1536;
  localparam int unsigned PSYS_WIDE_W   = 6144;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_SEND
  } dws_state_t;

endpackage

// File: rtl/in6144_out1536.sv
// AXI-Stream width downsizer: one wide word out as RATIO narrow beats, low slice first.
// Optional tlast pass-through is enabled by defining PSYS_DWS_TLAST_EN.
module in6144_out1536
  import psys_route_pkg::*;
#(
  parameter int unsigned IN_W  = PSYS_WIDE_W,
  parameter int unsigned OUT_W = PSYS_NARROW_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
`ifdef PSYS_DWS_TLAST_EN
  input  logic             s_axis_tlast,
  output logic             m_axis_tlast,
`endif
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready
);

  localparam int unsigned RATIO = IN_W / OUT_W;
  localparam int unsigned CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(RATIO - 1);

  dws_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  hold_q;
  logic             beat_hs, last_beat, wide_acc;

  assign m_axis_tvalid = (state_q == ST_SEND);
  assign beat_hs       = m_axis_tvalid & m_axis_tready;
  assign last_beat     = (cnt_q == LastCnt);
  assign s_axis_tready = (state_q == ST_IDLE) | (beat_hs & last_beat);
  assign wide_acc      = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (wide_acc) begin
      // Covers both the IDLE load and the no-bubble reload on the final beat.
      state_d = ST_SEND;
      cnt_d   = '0;
    end else if (beat_hs) begin
      if (last_beat) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (wide_acc) begin
      hold_q <= s_axis_tdata;
    end
  end

  // Mux on cnt instead of shifting so hold_q keeps the whole word visible.
  always_comb begin
    m_axis_tdata = '0;
    for (int i = 0; i < int'(RATIO); i++) begin
      if (cnt_q == CNT_W'(i)) m_axis_tdata = hold_q[i*OUT_W +: OUT_W];
    end
  end

`ifdef PSYS_DWS_TLAST_EN
  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b0;
    end else if (wide_acc) begin
      last_q <= s_axis_tlast;
    end
  end

  assign m_axis_tlast = last_q & last_beat;
`endif

endmodule
